// File: rtl/mem_load_pkg.sv
// Shared types and default sizing for the memory-load controller.
// Both the controller and its deadline timer import this package.
package mem_load_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } mem_load_state_t;

  localparam int LOAD_DATA_W    = 8;
  localparam int LOAD_ADDR_W    = 4;
  localparam int LOAD_BURST_LEN = 4;
  localparam int LOAD_MAX_LAT   = 5;

  // Bits needed to hold 0..max_val without wrapping.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/load_deadline_timer.sv
// Counts LOAD cycles since the last accept and flags the final cycle in
// which a burst may still finish inside the downstream latency window.
module load_deadline_timer
  import mem_load_pkg::*;
#(
  parameter int MAX_LAT = LOAD_MAX_LAT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int              EL_W      = cnt_width(MAX_LAT);
  localparam logic [EL_W-1:0] EXPIRE_AT = EL_W'(MAX_LAT - 1);
  localparam logic [EL_W-1:0] EL_MAX    = EL_W'(MAX_LAT);

  logic [EL_W-1:0] elapsed;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order in which the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      elapsed <= '0;
    end else if (clr) begin
      elapsed <= '0;
    end else if (en && (elapsed != EL_MAX)) begin
      elapsed <= elapsed + EL_W'(1);
    end
  end

  assign expire = (elapsed == EXPIRE_AT);

endmodule

// File: rtl/mem_load_ctrl.sv
// Streams a fixed-length burst from a valid/ready source into a memory write
// port, and signals done within MAX_LAT cycles of load_mem rising, or aborts with err.
module mem_load_ctrl
  import mem_load_pkg::*;
#(
  parameter int DATA_W    = LOAD_DATA_W,
  parameter int ADDR_W    = LOAD_ADDR_W,
  parameter int BURST_LEN = LOAD_BURST_LEN,
  parameter int MAX_LAT   = LOAD_MAX_LAT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_req,
  output logic              start_ack,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [DATA_W-1:0] src_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              load_mem,
  output logic              done,
  output logic              err,
  output logic              busy
);

  if ((BURST_LEN < 1) || (BURST_LEN > MAX_LAT)) begin : g_bad_burst_len
    $fatal(1, "mem_load_ctrl: BURST_LEN must satisfy 1 <= BURST_LEN <= MAX_LAT");
  end

  localparam int                BEAT_W    = cnt_width(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(BURST_LEN);

  mem_load_state_t   state;
  mem_load_state_t   state_next;
  logic [BEAT_W-1:0] beat;
  logic [ADDR_W-1:0] base;
  logic              accept;
  logic              last_beat;
  logic              expire;
  logic              deadline_miss;

  assign start_ack = (state == IDLE);
  assign src_ready = (state == LOAD);
  assign busy      = (state != IDLE);
  assign accept    = start_req && start_ack;
  assign mem_we    = src_valid && src_ready;
  assign mem_wdata = src_data;
  assign mem_addr  = base + ADDR_W'(beat);

  // A last beat landing on the deadline cycle still counts as success.
  assign last_beat     = mem_we && (beat == LAST_BEAT);
  assign deadline_miss = (state == LOAD) && expire && !last_beat;

  load_deadline_timer #(
    .MAX_LAT (MAX_LAT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (state == LOAD),
    .expire  (expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (last_beat || deadline_miss) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      beat <= '0;
      base <= '0;
    end else if (accept) begin
      beat <= '0;
      base <= start_addr;
    end else if (mem_we && (beat != BEAT_MAX)) begin
      beat <= beat + BEAT_W'(1);
    end
  end

  // load_mem tracks the next state, so it drops in the done/err cycle and
  // stays low for that one cycle even when a new request is accepted there.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      load_mem <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      load_mem <= (state_next == LOAD);
      done     <= last_beat;
      err      <= deadline_miss;
    end
  end

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Directed bench for mem_load_ctrl: burst timing, stalls, deadline abort,
// back-to-back restart, address wrap and mid-burst reset.
module tb_mem_load_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_req;
  logic       start_ack;
  logic [3:0] start_addr;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] src_data;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       load_mem;
  logic       done;
  logic       err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Window monitor: rise of load_mem followed by done within 0..5 cycles.
  int   win_hits = 0;
  int   win_age  = 0;
  logic win_open = 1'b0;
  logic lm_prev  = 1'b0;

  always #5 clk = ~clk;

  mem_load_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_req  (start_req),
    .start_ack  (start_ack),
    .start_addr (start_addr),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .load_mem   (load_mem),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (load_mem === 1'b1 && lm_prev === 1'b0) begin
      win_open = 1'b1;
      win_age  = 0;
    end else if (win_open) begin
      win_age++;
    end
    if (win_open && done === 1'b1) begin
      win_hits++;
      win_open = 1'b0;
    end else if (win_open && win_age >= 5) begin
      win_open = 1'b0;
    end
    lm_prev = load_mem;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle T-1: present a request that is accepted at the coming edge.
  task automatic do_start(input logic [3:0] addr);
    start_req  = 1'b1;
    start_addr = addr;
    src_valid  = 1'b0;
    #1;
    check("start_ack_idle", start_ack, 1'b1);
    step();
    start_req = 1'b0;
  endtask

  // One LOAD cycle: drive the source, check the write port, advance.
  task automatic beat_cycle(input logic v, input logic [7:0] d,
                            input logic [3:0] exp_addr, input string tag);
    src_valid = v;
    src_data  = d;
    #1;
    check({tag, "_we"},       mem_we,    v);
    check({tag, "_ready"},    src_ready, 1'b1);
    check({tag, "_load_mem"}, load_mem,  1'b1);
    check({tag, "_done"},     done,      1'b0);
    check({tag, "_err"},      err,       1'b0);
    if (v) begin
      check({tag, "_addr"},  mem_addr,  exp_addr);
      check({tag, "_wdata"}, mem_wdata, d);
    end
    step();
  endtask

  // Cycle after the burst ends: check the pulse, then that it lasted one cycle.
  task automatic expect_end(input logic exp_done, input logic exp_err, input string tag);
    src_valid = 1'b0;
    #1;
    check({tag, "_done"},     done,     exp_done);
    check({tag, "_err"},      err,      exp_err);
    check({tag, "_load_mem"}, load_mem, 1'b0);
    check({tag, "_busy"},     busy,     1'b0);
    step();
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_err_pulse"},  err,  1'b0);
  endtask

  initial begin
    reset_n    = 1'b0;
    start_req  = 1'b0;
    start_addr = '0;
    src_valid  = 1'b0;
    src_data   = '0;

    // Reset state
    step();
    step();
    check("rst_load_mem",  load_mem,  1'b0);
    check("rst_done",      done,      1'b0);
    check("rst_err",       err,       1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_start_ack", start_ack, 1'b1);
    check("rst_src_ready", src_ready, 1'b0);
    reset_n = 1'b1;
    step();

    // Test 1: base 2, no stalls -> writes 2,3,4,5; done at T+4
    do_start(4'h2);
    check("t1_busy", busy, 1'b1);
    beat_cycle(1'b1, 8'h10, 4'h2, "t1_b0");
    beat_cycle(1'b1, 8'h11, 4'h3, "t1_b1");
    beat_cycle(1'b1, 8'h12, 4'h4, "t1_b2");
    beat_cycle(1'b1, 8'h13, 4'h5, "t1_b3");
    expect_end(1'b1, 1'b0, "t1_end");
    check("t1_window_hit", win_hits, 1);

    // Test 2: one stall at T+1 -> done at T+5, no err
    do_start(4'h0);
    beat_cycle(1'b1, 8'h20, 4'h0, "t2_b0");
    beat_cycle(1'b0, 8'hFF, 4'h1, "t2_stall");
    beat_cycle(1'b1, 8'h21, 4'h1, "t2_b1");
    beat_cycle(1'b1, 8'h22, 4'h2, "t2_b2");
    beat_cycle(1'b1, 8'h23, 4'h3, "t2_b3");
    expect_end(1'b1, 1'b0, "t2_end");
    check("t2_window_hit", win_hits, 2);

    // Test 3: stalls at T+1 and T+3 -> 3 words, err at T+5, no done
    do_start(4'h8);
    beat_cycle(1'b1, 8'h30, 4'h8, "t3_b0");
    beat_cycle(1'b0, 8'hFF, 4'h9, "t3_stall0");
    beat_cycle(1'b1, 8'h31, 4'h9, "t3_b1");
    beat_cycle(1'b0, 8'hFF, 4'hA, "t3_stall1");
    beat_cycle(1'b1, 8'h32, 4'hA, "t3_b2");
    expect_end(1'b0, 1'b1, "t3_end");
    repeat (3) step();
    check("t3_window_miss", win_hits, 2);

    // Test 4: start_req held through done -> re-accept in the done cycle
    start_req  = 1'b1;
    start_addr = 4'h4;
    src_valid  = 1'b0;
    #1;
    check("t4_ack0", start_ack, 1'b1);
    step();
    start_addr = 4'h6;
    #1;
    check("t4_ack_busy", start_ack, 1'b0);
    beat_cycle(1'b1, 8'h40, 4'h4, "t4_a0");
    beat_cycle(1'b1, 8'h41, 4'h5, "t4_a1");
    beat_cycle(1'b1, 8'h42, 4'h6, "t4_a2");
    beat_cycle(1'b1, 8'h43, 4'h7, "t4_a3");
    src_valid = 1'b0;
    #1;
    check("t4_done1",     done,      1'b1);
    check("t4_load_low",  load_mem,  1'b0);
    check("t4_ack_done",  start_ack, 1'b1);
    step();
    start_req = 1'b0;
    check("t4_load_rise", load_mem, 1'b1);
    check("t4_done_gone", done,     1'b0);
    beat_cycle(1'b1, 8'h50, 4'h6, "t4_b0");
    beat_cycle(1'b1, 8'h51, 4'h7, "t4_b1");
    beat_cycle(1'b1, 8'h52, 4'h8, "t4_b2");
    beat_cycle(1'b1, 8'h53, 4'h9, "t4_b3");
    expect_end(1'b1, 1'b0, "t4_end");
    check("t4_window_hits", win_hits, 4);

    // Test 5: base E wraps -> E,F,0,1
    do_start(4'hE);
    beat_cycle(1'b1, 8'hA5, 4'hE, "t5_b0");
    beat_cycle(1'b1, 8'h5A, 4'hF, "t5_b1");
    beat_cycle(1'b1, 8'hC3, 4'h0, "t5_b2");
    beat_cycle(1'b1, 8'h3C, 4'h1, "t5_b3");
    expect_end(1'b1, 1'b0, "t5_end");
    check("t5_window_hit", win_hits, 5);

    // Test 6: reset at T+2 abandons the burst; a later start still works
    do_start(4'h3);
    beat_cycle(1'b1, 8'h60, 4'h3, "t6_b0");
    beat_cycle(1'b1, 8'h61, 4'h4, "t6_b1");
    reset_n   = 1'b0;
    src_valid = 1'b1;
    step();
    reset_n   = 1'b0;
    src_valid = 1'b0;
    #1;
    check("t6_rst_load_mem", load_mem,  1'b0);
    check("t6_rst_busy",     busy,      1'b0);
    check("t6_rst_done",     done,      1'b0);
    check("t6_rst_err",      err,       1'b0);
    check("t6_rst_ack",      start_ack, 1'b1);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_quiet_done", done, 1'b0);
      check("t6_quiet_err",  err,  1'b0);
    end
    check("t6_no_window_hit", win_hits, 5);
    do_start(4'h5);
    beat_cycle(1'b1, 8'h70, 4'h5, "t6_c0");
    beat_cycle(1'b1, 8'h71, 4'h6, "t6_c1");
    beat_cycle(1'b1, 8'h72, 4'h7, "t6_c2");
    beat_cycle(1'b1, 8'h73, 4'h8, "t6_c3");
    expect_end(1'b1, 1'b0, "t6_end");
    check("t6_window_hit", win_hits, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
